// File: rtl/msx_audio_dcblock_pkg.sv
// Shared MSX audio types and constants for the DC-blocking high-pass filter.
package msx_audio_dcblock_pkg;

  localparam int unsigned SAMPLE_W              = 16;
  localparam int unsigned GUARD_W               = 2;
  localparam int unsigned DCBLOCK_SHIFT_DEFAULT = 10;
  localparam int unsigned OVERRUN_W             = 8;

  typedef logic signed [SAMPLE_W-1:0] audio_sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_L = 2'd1,
    CALC_R = 2'd2,
    UPDATE = 2'd3
  } dcblock_state_t;

endpackage

// File: rtl/msx_dc_iir_step.sv
// One step of the first-order DC blocker: acc' = acc + (dx << SHIFT) - (acc >>> SHIFT).
module msx_dc_iir_step
  import msx_audio_dcblock_pkg::*;
#(
  parameter int unsigned SHIFT = DCBLOCK_SHIFT_DEFAULT
) (
  input  audio_sample_t                            x,
  input  audio_sample_t                            x_prev,
  input  logic signed [SAMPLE_W+GUARD_W+SHIFT-1:0] acc,
  output logic signed [SAMPLE_W+GUARD_W+SHIFT-1:0] acc_next,
  output audio_sample_t                            y_sat
);

  localparam int unsigned ACC_W = SAMPLE_W + GUARD_W + SHIFT;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32'sd32768);

  logic signed [SAMPLE_W:0]  diff;
  logic signed [ACC_W-1:0]   diff_ext;
  logic signed [ACC_W-1:0]   y_int;

  // Leak term uses floor truncation; no rounding bias is added.
  always_comb begin
    diff     = (SAMPLE_W+1)'(x) - (SAMPLE_W+1)'(x_prev);
    diff_ext = ACC_W'(diff);
    acc_next = acc + (diff_ext <<< SHIFT) - (acc >>> SHIFT);
    y_int    = acc_next >>> SHIFT;
    if (y_int > Y_MAX) begin
      y_sat = 16'sh7FFF;
    end else if (y_int < Y_MIN) begin
      y_sat = 16'sh8000;
    end else begin
      y_sat = SAMPLE_W'(y_int);
    end
  end

endmodule

// File: rtl/msx_audio_dcblock.sv
// Stereo DC-blocking filter between the mixer and the audio outputs; one
// shared IIR datapath is time-multiplexed over left then right per sample.
module msx_audio_dcblock
  import msx_audio_dcblock_pkg::*;
#(
  parameter int unsigned SHIFT = DCBLOCK_SHIFT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ce,
  input  logic                 bypass,
  input  audio_sample_t        in_L,
  input  audio_sample_t        in_R,
  output audio_sample_t        out_L,
  output audio_sample_t        out_R,
  output logic                 out_valid,
  output logic                 busy,
  output logic [OVERRUN_W-1:0] overrun
);

  localparam int unsigned ACC_W = SAMPLE_W + GUARD_W + SHIFT;

  dcblock_state_t          state;
  audio_sample_t           x_l, x_r, x_prev_l, x_prev_r, y_l, y_r;
  logic signed [ACC_W-1:0] acc_l, acc_r;

  audio_sample_t           step_x, step_x_prev, step_y;
  logic signed [ACC_W-1:0] step_acc, step_acc_next;

  // Steer the shared datapath to the right channel only during CALC_R.
  always_comb begin
    step_x      = x_l;
    step_x_prev = x_prev_l;
    step_acc    = acc_l;
    if (state == CALC_R) begin
      step_x      = x_r;
      step_x_prev = x_prev_r;
      step_acc    = acc_r;
    end
  end

  msx_dc_iir_step #(.SHIFT(SHIFT)) u_step (
    .x        (step_x),
    .x_prev   (step_x_prev),
    .acc      (step_acc),
    .acc_next (step_acc_next),
    .y_sat    (step_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x_l       <= '0;
      x_r       <= '0;
      x_prev_l  <= '0;
      x_prev_r  <= '0;
      y_l       <= '0;
      y_r       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_L     <= '0;
      out_R     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_ce) begin
            x_l   <= in_L;
            x_r   <= in_R;
            busy  <= 1'b1;
            state <= CALC_L;
          end
        end
        CALC_L: begin
          acc_l    <= step_acc_next;
          x_prev_l <= x_l;
          y_l      <= step_y;
          state    <= CALC_R;
        end
        CALC_R: begin
          acc_r    <= step_acc_next;
          x_prev_r <= x_r;
          y_r      <= step_y;
          state    <= UPDATE;
        end
        UPDATE: begin
          // Filter state keeps running under bypass so release is smooth.
          out_L     <= bypass ? x_l : y_l;
          out_R     <= bypass ? x_r : y_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      if ((state != IDLE) && sample_ce && (overrun != 8'hFF)) begin
        overrun <= overrun + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_msx_audio_dcblock.sv
// Directed bench for msx_audio_dcblock with a per-cycle reference model.
module tb_msx_audio_dcblock;

  localparam int SH = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_ce;
  logic               bypass;
  logic signed [15:0] in_L, in_R;
  logic signed [15:0] out_L, out_R;
  logic               out_valid;
  logic               busy;
  logic [7:0]         overrun;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  msx_audio_dcblock #(.SHIFT(SH)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_ce (sample_ce),
    .bypass    (bypass),
    .in_L      (in_L),
    .in_R      (in_R),
    .out_L     (out_L),
    .out_R     (out_R),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: y accumulates with unbounded precision, floor leak.
  function automatic longint iir(input longint acc, input int x, input int xp);
    return acc + longint'(x - xp) * (longint'(1) << SH) - (acc >>> SH);
  endfunction

  function automatic int sat(input longint acc);
    longint y;
    y = acc >>> SH;
    if (y > 32767) return 32767;
    if (y < -32768) return -32768;
    return int'(y);
  endfunction

  longint m_acc_l, m_acc_r;
  int     m_xl, m_xr, m_xpl, m_xpr, m_pend_l, m_pend_r;
  int     m_out_l, m_out_r, m_ovr, m_rem;
  bit     m_valid, m_busy;

  // Sample accepted only when idle; outputs appear 3 edges later.
  always @(posedge clk) begin
    if (reset) begin
      m_acc_l = 0; m_acc_r = 0; m_xl = 0; m_xr = 0; m_xpl = 0; m_xpr = 0;
      m_pend_l = 0; m_pend_r = 0; m_out_l = 0; m_out_r = 0;
      m_ovr = 0; m_rem = 0; m_valid = 0; m_busy = 0;
    end else begin
      m_valid = 0;
      if (m_rem == 0) begin
        if (sample_ce) begin
          m_xl = int'(in_L);
          m_xr = int'(in_R);
          m_acc_l = iir(m_acc_l, m_xl, m_xpl);
          m_acc_r = iir(m_acc_r, m_xr, m_xpr);
          m_xpl = m_xl;
          m_xpr = m_xr;
          m_pend_l = sat(m_acc_l);
          m_pend_r = sat(m_acc_r);
          m_rem = 3;
        end
      end else begin
        if (sample_ce && m_ovr < 255) m_ovr++;
        m_rem--;
        if (m_rem == 0) begin
          m_out_l = bypass ? m_xl : m_pend_l;
          m_out_r = bypass ? m_xr : m_pend_r;
          m_valid = 1;
        end
      end
      m_busy = (m_rem != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out_valid", out_valid == m_valid, int'(out_valid), int'(m_valid));
      chk("model_busy", busy == m_busy, int'(busy), int'(m_busy));
      chk("model_overrun", int'(overrun) == m_ovr, int'(overrun), m_ovr);
      chk("model_out_L", int'(out_L) == m_out_l, int'(out_L), m_out_l);
      chk("model_out_R", int'(out_R) == m_out_r, int'(out_R), m_out_r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic strobe(input logic signed [15:0] l, input logic signed [15:0] r);
    sample_ce = 1'b1;
    in_L = l;
    in_R = r;
    tick();
    sample_ce = 1'b0;
  endtask

  task automatic run_sample(input logic signed [15:0] l, input logic signed [15:0] r);
    int n;
    strobe(l, r);
    n = 0;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    if (!out_valid) chk("valid_timeout", 1'b0, n, 3);
  endtask

  initial begin
    int prev, d, nv;
    reset = 1'b1; sample_ce = 1'b0; bypass = 1'b0; in_L = '0; in_R = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_L", out_L == 16'sh0000, int'(out_L), 0);
    chk("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    chk("rst_busy", busy == 1'b0, int'(busy), 0);
    chk("rst_overrun", overrun == 8'h00, int'(overrun), 0);
    reset = 1'b0;
    tick();

    // First sample: step passes through, exactly 3 cycles of latency.
    strobe(16'sh4000, 16'sh0000);
    tick(); chk("lat_c1", out_valid == 1'b0, int'(out_valid), 0);
    tick(); chk("lat_c2", out_valid == 1'b0, int'(out_valid), 0);
    tick(); chk("lat_c3", out_valid == 1'b1, int'(out_valid), 1);
    chk("step_out_L", out_L == 16'sh4000, int'(out_L), 'h4000);

    // Constant input decays toward zero.
    prev = int'(out_L);
    for (int i = 1; i < 1024; i++) begin
      run_sample(16'sh4000, 16'sh0000);
      chk("decay_monotonic", int'(out_L) <= prev, int'(out_L), prev);
      prev = int'(out_L);
    end
    d = int'(out_L) - 'h178B;
    chk("decay_1024", d >= -4 && d <= 4, int'(out_L), 'h178B);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      run_sample(16'sh0000, 16'sh0000);
      chk("zero_in", out_L == 16'sh0000, int'(out_L), 0);
    end

    // Full-scale negative step must clamp, not wrap.
    do_reset();
    run_sample(16'sh0000, 16'sh7FFF);
    chk("pos_full", out_R == 16'sh7FFF, int'(out_R), 32767);
    run_sample(16'sh0000, 16'sh8000);
    chk("neg_sat", out_R == 16'sh8000, int'(out_R), -32768);
    for (int i = 0; i < 3; i++) begin
      run_sample(16'sh0000, 16'sh8000);
      chk("no_wrap", out_R[15] == 1'b1, int'(out_R), -32768);
    end

    // Back-to-back strobes: second is dropped.
    do_reset();
    sample_ce = 1'b1; in_L = 16'sh0100; in_R = 16'sh0200;
    tick(); tick();
    sample_ce = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) nv++;
    end
    chk("one_valid", nv == 1, nv, 1);
    chk("overrun_1", overrun == 8'h01, int'(overrun), 1);
    sample_ce = 1'b1;
    for (int i = 0; i < 420; i++) tick();
    sample_ce = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("overrun_sat", overrun == 8'hFF, int'(overrun), 255);

    // Reset while in CALC_R abandons the sample.
    do_reset();
    strobe(16'sh2000, 16'sh1000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_valid", out_valid == 1'b0, int'(out_valid), 0);
      chk("abort_out_L", out_L == 16'sh0000, int'(out_L), 0);
      chk("abort_out_R", out_R == 16'sh0000, int'(out_R), 0);
    end
    run_sample(16'sh1000, 16'sh0000);
    chk("after_abort", out_L == 16'sh1000, int'(out_L), 'h1000);

    // Bypass passes the raw input while the filter keeps running.
    do_reset();
    bypass = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_sample(16'sh1234, 16'sh0000);
      chk("bypass_out_L", out_L == 16'sh1234, int'(out_L), 'h1234);
    end
    bypass = 1'b0;
    run_sample(16'sh1234, 16'sh0000);
    chk("bypass_release", int'(out_L) == sat(m_acc_l), int'(out_L), sat(m_acc_l));
    chk("bypass_release_decayed", int'(out_L) < 'h1234, int'(out_L), 'h1234);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/msx_audio_dcblock.md
MSX_AUDIO_DCBLOCK -- requirements
Module: msx_audio_dcblock

Interface
REQ-001 SHALL have parameter SHIFT, default 10: pole = 1 - 2^-SHIFT, legal range 6..14.
REQ-002 SHALL have port clk, input, 1: system clock, the same clock as the audio mixer.
REQ-003 SHALL have port reset, input, 1: reset for the block; the clock domain is single, and reset is synchronous and active-high.
REQ-004 SHALL have port sample_ce, input, 1: single-cycle strobe marking a new mixer sample.
REQ-005 SHALL have port bypass, input, 1: when 1, the filter output is replaced by the latched input.
REQ-006 SHALL have port in_L, input, 16: signed left sample from the mixer.
REQ-007 SHALL have port in_R, input, 16: signed right sample from the mixer.
REQ-008 SHALL have port out_L, output, 16: signed filtered left sample, registered.
REQ-009 SHALL have port out_R, output, 16: signed filtered right sample, registered.
REQ-010 SHALL have port out_valid, output, 1: one-cycle pulse when out_L/out_R update.
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port overrun, output, 8: saturating count of dropped sample_ce strobes.

Function
REQ-013 SHALL implement y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> SHIFT) independently per channel.
REQ-014 SHALL hold y as a signed accumulator of 18+SHIFT bits (16 integer + 2 guard + SHIFT fraction); the x-difference SHALL be left-shifted by SHIFT before the add.
REQ-015 SHALL use arithmetic shift; truncation is toward negative infinity and no rounding term is added.
REQ-016 SHALL form each output as acc >>> SHIFT, saturated to 16'h7FFF / 16'h8000.
REQ-017 SHALL use FSM states IDLE -> CALC_L -> CALC_R -> UPDATE -> IDLE, one cycle each.
REQ-018 SHALL latch in_L and in_R in IDLE when sample_ce=1 and move to CALC_L.
REQ-019 SHALL update the left state (acc_L, x_prev_L) in CALC_L and the right state in CALC_R, using one shared datapath.
REQ-020 SHALL load out_L/out_R and pulse out_valid in UPDATE; out_valid is high exactly 3 cycles after the accepted sample_ce edge.
REQ-021 SHALL ignore sample_ce in any non-IDLE state, increment overrun saturating at 8'hFF, and leave the in-flight sample unaffected.
REQ-022 SHALL, with bypass=1, load out_L/out_R with the latched inputs in UPDATE, and keep updating the filter state so bypass release is glitch-limited.
REQ-023 SHALL, when bypass changes mid-sample, sample it in UPDATE only.
REQ-024 SHALL keep out_L/out_R stable between out_valid pulses.

Reset
REQ-025 SHALL, on reset=1 at a clk edge, force FSM=IDLE and clear acc_L, acc_R, x_prev_L, x_prev_R, latched inputs, out_L, out_R, out_valid, busy and overrun to 0.
REQ-026 SHALL, if reset is asserted in CALC_L/CALC_R/UPDATE, produce no out_valid pulse for the abandoned sample.
REQ-027 SHALL, if sample_ce coincides with reset, have reset win and not accept the sample.

Structure
REQ-028 SHALL place typedef audio_sample_t (signed 16) and constant DCBLOCK_SHIFT_DEFAULT=10 in the shared MSX package.
REQ-029 SHALL use one combinational sub-module msx_dc_iir_step (inputs x, x_prev, acc; outputs acc_next, y_sat), instanced once and time-shared across channels.
REQ-030 SHALL sit between the mixer's audio_L/audio_R and the top-level audio outputs, with sample_ce driven from the audio sample-rate enable.

Verification
REQ-031 SHALL cover: reset, then one strobe with in_L=16'h4000 -> out_L=16'h4000 and out_valid exactly 3 cycles later.
REQ-032 SHALL cover: in_L held at 16'h4000 for 1024 strobes, SHIFT=10 -> out_L within 16'h178B +/-4, monotonically decaying; with in_L constant 0 -> out_L stays 0.
REQ-033 SHALL cover: in_R=16'h7FFF for one sample, then 16'h8000 -> out_R=16'h8000 (saturated), with no wrap to a positive value.
REQ-034 SHALL cover: sample_ce on two consecutive cycles -> second strobe dropped, overrun=1, one out_valid; 300 such drops -> overrun=8'hFF.
REQ-035 SHALL cover: reset asserted in CALC_R -> no out_valid, all outputs 0; next strobe with in_L=16'h1000 -> out_L=16'h1000.
REQ-036 SHALL cover: bypass=1 with in_L=16'h1234 -> out_L=16'h1234 every sample; release bypass after 8 samples -> out_L equals the free-running filter model value.
